// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-owning fetch front end.
// Drives a combinational-read instruction memory, buffers fetched words in a
// 2-entry queue and presents them to decode over a valid/ready handshake.
// Execute redirects flush the queue and reload the fetch PC.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When it is defined, a
// misaligned redirect halts fetch and raises misalign_err until an aligned
// redirect arrives. When it is undefined, redirect targets are force-aligned
// and misalign_err stays 0.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc_plus4,
  output logic              misalign_err
);

  typedef enum logic [0:0] {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

  mode_e       r_mode;
  logic [31:0] r_pc_f;
  logic [31:0] r_q_instr [2];
  logic [31:0] r_q_pc    [2];
  logic        r_head;
  logic [1:0]  r_count;
  logic        r_misalign;

  logic        w_pop;
  logic        w_fetch_en;
  logic        w_tail;
  logic        w_misaligned;
  logic [31:0] w_redirect_target;
  logic        w_valid;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Handshake, fetch enable, tail slot and redirect target selection.
  always_comb begin
    w_valid           = (r_count != 2'd0);
    w_pop             = w_valid & out_ready;
    w_fetch_en        = (r_mode == MODE_RUN) & ~redirect_valid &
                        ((r_count != 2'd2) | w_pop);
    // With count==2 the tail wraps onto the head slot, which is freed by the pop.
    w_tail            = r_head ^ r_count[0];
    w_redirect_target = w_misaligned ? redirect_pc : {redirect_pc[31:2], 2'b00};
  end

  // Fetch PC, queue storage, occupancy and RUN/HALT mode state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f       <= RESET_PC;
      r_count      <= 2'd0;
      r_head       <= 1'b0;
      r_mode       <= MODE_RUN;
      r_misalign   <= 1'b0;
      r_q_instr[0] <= NOP_INSTR;
      r_q_instr[1] <= NOP_INSTR;
      r_q_pc[0]    <= 32'h0000_0000;
      r_q_pc[1]    <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // Redirect wins over fetch and pop; a same-cycle pop is discarded by the flush.
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_pc_f  <= w_redirect_target;
      if (w_misaligned) begin
        r_mode     <= MODE_HALT;
        r_misalign <= 1'b1;
      end else begin
        r_mode     <= MODE_RUN;
        r_misalign <= 1'b0;
      end
    end else begin
      if (w_fetch_en) begin
        r_q_instr[w_tail] <= imem_instr;
        r_q_pc[w_tail]    <= r_pc_f;
        r_pc_f            <= r_pc_f + 32'd4;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_fetch_en} - {1'b0, w_pop};
    end
  end

  // Head-entry outputs; an empty queue presents a NOP at PC 0.
  always_comb begin
    imem_addr    = r_pc_f[ADDR_W+1:2];
    out_valid    = w_valid;
    out_instr    = w_valid ? r_q_instr[r_head] : NOP_INSTR;
    out_pc       = w_valid ? r_q_pc[r_head] : 32'h0000_0000;
    out_pc_plus4 = out_pc + 32'd4;
    misalign_err = r_misalign;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the stimulus pushes the expected
// {pc, instr} of every instruction decode will accept; a negedge monitor pops
// and compares on every accepted handshake. Cycle-exact latency points are
// checked directly by the stimulus.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_err;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .misalign_err   (misalign_err)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word i holds 32'hC0DE_0000 | i, so word 16 is C0DE_0010.
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'hC0DE_0000 | {24'h000000, pc[9:2]};
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = exp_instr(pc);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got pc %h instr %h expected nothing", out_pc, out_instr);
      end else begin
        m_e = sb_q.pop_front();
        if (out_pc !== m_e.pc || out_instr !== m_e.instr || out_pc_plus4 !== (m_e.pc + 32'd4)) begin
          errors++;
          $display("FAIL out_entry: got pc %h instr %h pc4 %h expected pc %h instr %h pc4 %h",
                   out_pc, out_instr, out_pc_plus4, m_e.pc, m_e.instr, m_e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hC0DE_0000 | i;
    end
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;

    // Reset state.
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc_plus4, 32'd4);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rel_valid0", {31'd0, out_valid}, 32'd0);

    // First valid one cycle after first post-reset edge, then backpressure.
    tick();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'd0);
    push_exp(32'h00);
    push_exp(32'h04);
    push_exp(32'h08);
    push_exp(32'h0C);
    push_exp(32'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_pc", out_pc, 32'd0);
    end
    chk("bp_pcf_8", {24'd0, imem_addr}, 32'd2);

    // Release backpressure: five back-to-back accepts with no bubbles.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end

    // Redirect to 0x40 with the queue full (entries 0x14, 0x18 dropped).
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    push_exp(32'h40);
    tick();
    redirect_valid = 1'b0;
    chk("redir_bubble", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("redir_valid", {31'd0, out_valid}, 32'd1);

    // Redirect to 0x3FC while 0x40 is popped: wrap of imem_addr.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_03FC;
    push_exp(32'h3FC);
    push_exp(32'h400);
    tick();
    redirect_valid = 1'b0;
    chk("wrap_bubble", {31'd0, out_valid}, 32'd0);
    chk("wrap_addr255", {24'd0, imem_addr}, 32'd255);
    tick();
    chk("wrap_addr0", {24'd0, imem_addr}, 32'd0);
    tick();

    // Redirect to misaligned 0x22 while 0x400 is popped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0022;
`ifndef FETCH_MISALIGN_CHK_EN
    push_exp(32'h20);
`endif
    tick();
    redirect_valid = 1'b0;
    chk("mis_bubble", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_set", {31'd0, misalign_err}, 32'd1);
    tick();
    chk("mis_halt_valid", {31'd0, out_valid}, 32'd0);
    chk("mis_halt_addr", {24'd0, imem_addr}, 32'd8);
    chk("mis_hold", {31'd0, misalign_err}, 32'd1);
    tick();
    chk("mis_halt_valid2", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    push_exp(32'h10);
    tick();
    redirect_valid = 1'b0;
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);
    chk("mis_clear_bubble", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mis_resume_valid", {31'd0, out_valid}, 32'd1);
    tick();
`else
    chk("mis_flag_off", {31'd0, misalign_err}, 32'd0);
    tick();
    chk("align_valid", {31'd0, out_valid}, 32'd1);
    tick();
`endif
    out_ready = 1'b0;
    tick();
    tick();

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", out_instr, NOP);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_pc4", out_pc_plus4, 32'd4);
    chk("arst_addr", {24'd0, imem_addr}, 32'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("arst_rel_valid", {31'd0, out_valid}, 32'd0);
    push_exp(32'h00);
    push_exp(32'h04);
    push_exp(32'h08);
    tick();
    chk("restart_pc", out_pc, 32'd0);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- PC-owning fetch front end. Drives the word address into the combinational-read instruction memory (8-bit word address, 32-bit instruction) and captures the returned word.
- Hands fetched instructions to decode through a 2-entry output queue with a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes its queue on each redirect.

Parameters:
- ADDR_W, 8: instruction memory word-address width (256 words).
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: value driven on out_instr while the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_addr  out  ADDR_W  word address to instruction memory; equals pc_f[ADDR_W+1:2].
- imem_instr  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  byte-address target for the redirect.
- out_valid  out  1  head of the queue holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  byte PC of the head instruction.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32.
- misalign_err  out  1  misaligned-redirect flag; see Optional Feature.

Behaviour:
- Internal state: fetch PC pc_f (32 bits); 2-entry FIFO of {instr, pc}; count in 0..2; mode in RUN/HALT (HALT exists only with the macro).
- Reset (asynchronous, rst_n=0):
  - pc_f=RESET_PC, count=0, mode=RUN.
  - Outputs: out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_plus4=4, misalign_err=0.
  - imem_addr follows pc_f, so it reads RESET_PC[ADDR_W+1:2].
- pop = out_valid & out_ready.
- fetch_en = mode==RUN & !redirect_valid & (count<2 | pop).
- On a clock edge with fetch_en: enqueue {imem_instr, pc_f} at the tail; pc_f <= pc_f+4, wrapping modulo 2^32.
- imem_addr wraps from 2^ADDR_W-1 to 0. Only pc_f[ADDR_W+1:2] reaches the memory; upper PC bits are carried in out_pc but ignored for addressing.
- On an edge with redirect_valid:
  - Redirect has priority over fetch and pop.
  - Queue flushed (count=0).
  - pc_f <= {redirect_pc[31:2], 2'b00}.
  - Any pop in the same cycle counts as consumed by decode, but its entry is also discarded by the flush.
- Count update without redirect: count += fetch_en − pop. A simultaneous fetch and pop when full keeps count=2, with head/tail rotating.
- Outputs are driven from the head entry. When count=0: out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_plus4=4.
- The head entry stays stable while out_valid=1 and out_ready=0.
- Latency:
  - First instruction is valid in the cycle after the first clock edge following rst_n release.
  - Redirect asserted in cycle N: out_valid=0 in N+1; the target instruction is valid in N+1's successor (N+2).
  - Steady state, out_ready tied 1: one instruction per cycle, no bubbles.
- Backpressure: with out_ready=0, fetch continues until count=2, then pc_f holds. No instruction is lost or duplicated.
- rst_n asserted mid-operation: queue and PC reset immediately; nothing is emitted until after rst_n release.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 flushes the queue, loads pc_f=redirect_pc unmodified, enters HALT (no fetches), and sets misalign_err=1.
  - misalign_err stays 1 until an aligned redirect, which returns mode to RUN and clears the flag, or until reset.
- Undefined:
  - The low two bits of redirect_pc are always cleared.
  - HALT is never entered.
  - misalign_err is tied to 0.

Test Plan:
- Reset, out_ready=1, memory preloaded with words W0..W4 at 0..4 -> out_pc sequence 0,4,8,12,16 with out_instr=W0..W4 on consecutive cycles; out_valid first high 1 cycle after the first post-reset edge.
- Backpressure: out_ready=0 for 5 cycles after the first valid -> out_pc holds 0; pc_f stops at 8 (count=2); after out_ready=1, the sequence continues 0,4,8 with no gaps or duplicates.
- Redirect to 0x40 while count=2 -> next cycle out_valid=0, then out_pc=0x40, out_instr=mem[16]; old entries 4 and 8 never appear.
- Wrap: redirect to 0x3FC -> imem_addr=255 then 0; out_pc=0x3FC then 0x400; out_instr=mem[255] then mem[0].
- Redirect to 0x22:
  - Macro off: out_pc=0x20.
  - Macro on: misalign_err=1 and out_valid stays 0; a later redirect to 0x10 clears misalign_err and emits out_pc=0x10.
- Assert rst_n=0 asynchronously mid-stream (between edges) -> out_valid=0 and out_instr=0x00000013 immediately; after release, fetch restarts at RESET_PC.
